// File: rtl/alram_1x_pkg.sv
// Shared constants and types for the alram_1x small register-file RAM.
// Optional feature macro: ALRAM_1X_BYPASS_EN (write-first on same-address collision).
package alram_1x_pkg;

  localparam int WID_DEF  = 10;
  localparam int AWID_DEF = 2;
  localparam int DEP_DEF  = 1 << AWID_DEF;

  // Data word at the default width
  typedef logic [WID_DEF-1:0] word_t;

endpackage

// File: rtl/alram_1x_mem.sv
// Raw storage array with a single synchronous write port and an
// asynchronous read tap. It has no reset: the array contents are not
// cleared, and the valid bitmap in the top masks unwritten words.
module alram_1x_mem
  import alram_1x_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int AWID = AWID_DEF,
  parameter int DEP  = 1 << AWID
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AWID-1:0] wa,
  input  logic [WID-1:0]  wdi,
  input  logic [AWID-1:0] ra,
  output logic [WID-1:0]  rdat
);

  logic [WID-1:0] mem_q [DEP];

  // Write port: store wdi at wa when enabled
  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wdi;
  end

  // The read tap is combinational; the top registers the result
  assign rdat = mem_q[ra];

endmodule

// File: rtl/alram_1x.sv
// alram_1x: DEP x WID RAM with one write port, one read port and a
// registered read. A per-word valid bitmap is cleared by reset, so every
// address reads zero until it is written again. Collisions read old data
// by default. Defining ALRAM_1X_BYPASS_EN selects write-first behaviour.
// DEP must equal 2**AWID, so every address value is in range.
module alram_1x
  import alram_1x_pkg::*;
#(
  parameter int WID  = WID_DEF,
  parameter int AWID = AWID_DEF,
  parameter int DEP  = 1 << AWID
) (
  input  logic            clk,
  input  logic            rst,
  output logic [WID-1:0]  rdo,
  input  logic [AWID-1:0] ra,
  input  logic [WID-1:0]  wdi,
  input  logic [AWID-1:0] wa,
  input  logic            we
);

  logic [DEP-1:0] valid_q;
  logic [WID-1:0] rdo_q, rdo_d;
  logic [WID-1:0] mem_rd;
  logic           we_en;

  // The array has no reset, so gate its writes here.
  // Writes presented during reset must not land.
  assign we_en = we & ~rst;

  alram_1x_mem #(
    .WID  (WID),
    .AWID (AWID),
    .DEP  (DEP)
  ) u_mem (
    .clk  (clk),
    .we   (we_en),
    .wa   (wa),
    .wdi  (wdi),
    .ra   (ra),
    .rdat (mem_rd)
  );

  // Mark written words valid; reset invalidates the whole array at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     valid_q     <= '0;
    else if (we) valid_q[wa] <= 1'b1;
  end

  // Next read value: masked array data, optionally bypassed on collision
  always_comb begin
    rdo_d = valid_q[ra] ? mem_rd : '0;
`ifdef ALRAM_1X_BYPASS_EN
    if (we && (wa == ra)) rdo_d = wdi;
`endif
  end

  // Read register: reloads every cycle, and reset discards any in-flight result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdo_q <= '0;
    else     rdo_q <= rdo_d;
  end

  assign rdo = rdo_q;

endmodule

// File: tb/tb_alram_1x.sv
// Self-checking bench for alram_1x (WID=10, AWID=2): directed vector table,
// an async reset sequence, then random traffic against a behavioural model.
module tb_alram_1x;
  import alram_1x_pkg::*;

  localparam int W = 10;
  localparam int A = 2;
  localparam int D = 4;
`ifdef ALRAM_1X_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] rdo;
  logic [A-1:0] ra  = '0;
  logic [W-1:0] wdi = '0;
  logic [A-1:0] wa  = '0;
  logic         we  = 1'b0;

  int total = 0;
  int bad   = 0;

  // Behavioural model: stored words plus a written-since-reset flag per address
  word_t m_mem [D];
  bit    m_vld [D];

  alram_1x #(.WID(W), .AWID(A), .DEP(D)) dut (
    .clk (clk),
    .rst (rst),
    .rdo (rdo),
    .ra  (ra),
    .wdi (wdi),
    .wa  (wa),
    .we  (we)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         w;
    logic [A-1:0] a;
    logic [W-1:0] d;
    logic [A-1:0] r;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vt [19];

  function automatic void check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  function automatic word_t model_read(input logic w, input logic [A-1:0] a,
                                       input logic [W-1:0] d, input logic [A-1:0] r);
    if (BYP && w && a == r) return d;
    return m_vld[r] ? m_mem[r] : '0;
  endfunction

  // One cycle: drive on the falling edge, then sample just after the rising edge.
  // The model is advanced in the same step.
  task automatic step(input logic w, input logic [A-1:0] a, input logic [W-1:0] d,
                      input logic [A-1:0] r, output logic [W-1:0] got, output logic [W-1:0] mexp);
    @(negedge clk);
    we = w; wa = a; wdi = d; ra = r;
    mexp = model_read(w, a, d, r);
    @(posedge clk);
    #1;
    got = rdo;
    if (w) begin
      m_mem[a] = d;
      m_vld[a] = 1'b1;
    end
    we = 1'b0;
  endtask

  initial begin
    logic [W-1:0] got, mexp;
    for (int i = 0; i < D; i++) begin
      m_vld[i] = 1'b0;
      m_mem[i] = '0;
    end

    // Directed table: reset reads, single write, fill/readback, collision, independent ports
    vt[0]  = '{1'b0, 2'd0, 10'h000, 2'd0, 10'h000};
    vt[1]  = '{1'b0, 2'd0, 10'h000, 2'd1, 10'h000};
    vt[2]  = '{1'b0, 2'd0, 10'h000, 2'd2, 10'h000};
    vt[3]  = '{1'b0, 2'd0, 10'h000, 2'd3, 10'h000};
    vt[4]  = '{1'b1, 2'd2, 10'h155, 2'd0, 10'h000};
    vt[5]  = '{1'b0, 2'd0, 10'h000, 2'd2, 10'h155};
    vt[6]  = '{1'b1, 2'd0, 10'h001, 2'd1, 10'h000};
    vt[7]  = '{1'b1, 2'd1, 10'h002, 2'd2, 10'h155};
    vt[8]  = '{1'b1, 2'd2, 10'h004, 2'd3, 10'h000};
    vt[9]  = '{1'b1, 2'd3, 10'h008, 2'd0, 10'h001};
    vt[10] = '{1'b0, 2'd0, 10'h000, 2'd3, 10'h008};
    vt[11] = '{1'b0, 2'd0, 10'h000, 2'd2, 10'h004};
    vt[12] = '{1'b0, 2'd0, 10'h000, 2'd1, 10'h002};
    vt[13] = '{1'b0, 2'd0, 10'h000, 2'd0, 10'h001};
    vt[14] = '{1'b1, 2'd1, 10'h0AA, 2'd0, 10'h001};
    vt[15] = '{1'b1, 2'd1, 10'h3FF, 2'd1, (BYP ? 10'h3FF : 10'h0AA)};
    vt[16] = '{1'b0, 2'd0, 10'h000, 2'd1, 10'h3FF};
    vt[17] = '{1'b1, 2'd0, 10'h123, 2'd3, 10'h008};
    vt[18] = '{1'b0, 2'd0, 10'h000, 2'd0, 10'h123};

    // Reset state
    #12;
    check("reset_rdo", rdo, 10'h000);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 19; i++) begin
      step(vt[i].w, vt[i].a, vt[i].d, vt[i].r, got, mexp);
      check($sformatf("vec%0d", i), got, vt[i].exp);
      check($sformatf("vec%0d_model", i), got, mexp);
    end

    // Async reset between edges: rdo clears at once, and a write during reset is dropped
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_rdo", rdo, 10'h000);
    we = 1'b1; wa = 2'd1; wdi = 10'h055; ra = 2'd1;
    @(posedge clk);
    #1;
    check("rst_hold_rdo", rdo, 10'h000);
    @(negedge clk);
    we = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < D; i++) m_vld[i] = 1'b0;
    for (int i = 0; i < D; i++) begin
      step(1'b0, 2'd0, 10'h000, i[A-1:0], got, mexp);
      check($sformatf("post_rst_rd%0d", i), got, 10'h000);
    end
    // Rewrite after reset, then read it back
    step(1'b1, 2'd3, 10'h2C3, 2'd2, got, mexp);
    check("post_rst_wr", got, 10'h000);
    step(1'b0, 2'd0, 10'h000, 2'd3, got, mexp);
    check("post_rst_rdback", got, 10'h2C3);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      logic         rw;
      logic [A-1:0] raa, rra;
      logic [W-1:0] rd;
      rw  = 1'($urandom_range(0, 1));
      raa = A'($urandom_range(0, D-1));
      rra = A'($urandom_range(0, D-1));
      rd  = W'($urandom);
      step(rw, raa, rd, rra, got, mexp);
      check($sformatf("rand%0d", i), got, mexp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
